// File: rtl/ksa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone arithmetic blocks.
// The group generate/propagate pair and its combine operator live here so every level uses one definition.
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels needed to cover a carry chain of the given width.
    function automatic int ksa_levels(input int bits);
        int lv;
        lv = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < bits) lv = i + 1;
        end
        return lv;
    endfunction

    // Kogge-Stone cell: hi covers the more significant span, lo the span just below it.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ksa_prefix_stage.sv
// One registered Kogge-Stone prefix level: combines each bit with the one SPAN below it.
// Raw propagate and carry-in ride along untouched so the final sum stage can use them.
module ksa_prefix_stage
    import ksa_pkg::*;
#(
    parameter int BITS = 64,
    parameter int SPAN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              valid_i,
    input  gp_t  [BITS-1:0]   gp_i,
    input  logic [BITS-1:0]   p_i,
    input  logic              cin_i,
    output logic              valid_o,
    output gp_t  [BITS-1:0]   gp_o,
    output logic [BITS-1:0]   p_o,
    output logic              cin_o
);

    gp_t  [BITS-1:0] gp_d;
    gp_t  [BITS-1:0] gp_q;
    logic [BITS-1:0] p_q;
    logic            cin_q;
    logic            valid_q;

    always_comb begin
        // NOTE: gp_d gets a full default before the loop, so no bit is left unassigned and no latch is inferred.
        gp_d = gp_i;
        for (int i = SPAN; i < BITS; i++) begin
            gp_d[i] = gp_combine(gp_i[i], gp_i[i-SPAN]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            gp_q    <= '0;
            p_q     <= '0;
            cin_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            gp_q    <= gp_d;
            p_q     <= p_i;
            cin_q   <= cin_i;
        end
    end

    assign valid_o = valid_q;
    assign gp_o    = gp_q;
    assign p_o     = p_q;
    assign cin_o   = cin_q;

endmodule

// File: rtl/ksa_sub_pipe.sv
// Fully pipelined Kogge-Stone subtractor: d = a - b - bin computed as a + ~b + ~bin,
// one register per prefix level, single global stall enable driven by the output handshake.
module ksa_sub_pipe
    import ksa_pkg::*;
#(
    parameter int BITS   = 64,
    parameter int LEVELS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS:0]   d,
    output logic            zero,
    output logic            ovf
);

    if (LEVELS != ksa_levels(BITS)) begin : g_bad_levels
        $error("ksa_sub_pipe: LEVELS must equal ceil(log2(BITS))");
    end

    logic adv;

    // S0: operand capture
    logic            s0_v_q;
    logic [BITS-1:0] s0_a_q;
    logic [BITS-1:0] s0_b_q;
    logic            s0_bin_q;

    // S1: bitwise generate/propagate, carry-in is the inverted borrow-in
    gp_t [BITS-1:0]  s1_gp_d;
    gp_t [BITS-1:0]  s1_gp_q;
    logic            s1_v_q;
    logic            s1_cin_q;

    // Prefix tree interconnect; index 0 feeds the first level, index LEVELS is the last register
    gp_t  [BITS-1:0] lvl_gp  [LEVELS+1];
    logic [BITS-1:0] lvl_p   [LEVELS+1];
    logic            lvl_cin [LEVELS+1];
    logic            lvl_v   [LEVELS+1];

    // Output stage
    logic [BITS-1:0] carry_into;
    logic [BITS-1:0] sum;
    logic            cout;
    logic [BITS:0]   d_d;
    logic            zero_d;
    logic            ovf_d;
    logic [BITS:0]   d_q;
    logic            zero_q;
    logic            ovf_q;
    logic            out_v_q;

    assign adv      = !out_v_q || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are cleared along with the valid bits so d reads 0 after reset, never stale in-flight data.
        if (!rst_n) begin
            s0_v_q   <= 1'b0;
            s0_a_q   <= '0;
            s0_b_q   <= '0;
            s0_bin_q <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking updates let every stage sample its predecessor's pre-edge value on the same clock.
            s0_v_q   <= in_valid;
            s0_a_q   <= a;
            s0_b_q   <= b;
            s0_bin_q <= bin;
        end
    end

    always_comb begin
        s1_gp_d = '0;
        for (int i = 0; i < BITS; i++) begin
            s1_gp_d[i].g = s0_a_q[i] & ~s0_b_q[i];
            s1_gp_d[i].p = s0_a_q[i] ^ ~s0_b_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_gp_q  <= '0;
            s1_cin_q <= 1'b0;
        end else if (adv) begin
            s1_v_q   <= s0_v_q;
            s1_gp_q  <= s1_gp_d;
            s1_cin_q <= ~s0_bin_q;
        end
    end

    // Folding the carry-in into bit 0's generate makes every group generate a true carry-out.
    always_comb begin
        lvl_gp[0] = s1_gp_q;
        lvl_gp[0][0].g = s1_gp_q[0].g | (s1_gp_q[0].p & s1_cin_q);
        lvl_p[0] = '0;
        for (int i = 0; i < BITS; i++) begin
            lvl_p[0][i] = s1_gp_q[i].p;
        end
    end

    assign lvl_cin[0] = s1_cin_q;
    assign lvl_v[0]   = s1_v_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        ksa_prefix_stage #(
            .BITS (BITS),
            .SPAN (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv),
            .valid_i (lvl_v[k]),
            .gp_i    (lvl_gp[k]),
            .p_i     (lvl_p[k]),
            .cin_i   (lvl_cin[k]),
            .valid_o (lvl_v[k+1]),
            .gp_o    (lvl_gp[k+1]),
            .p_o     (lvl_p[k+1]),
            .cin_o   (lvl_cin[k+1])
        );
    end

    always_comb begin
        carry_into    = '0;
        carry_into[0] = lvl_cin[LEVELS];
        for (int i = 1; i < BITS; i++) begin
            carry_into[i] = lvl_gp[LEVELS][i-1].g;
        end
        cout   = lvl_gp[LEVELS][BITS-1].g;
        sum    = lvl_p[LEVELS] ^ carry_into;
        d_d    = {~cout, sum};
        zero_d = (sum == '0);
        // Signed overflow of a + ~b: carry into the sign bit differs from carry out of it.
        ovf_d  = carry_into[BITS-1] ^ cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            d_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            out_v_q <= lvl_v[LEVELS];
            d_q     <= d_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = out_v_q;
    assign d         = d_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule
